// File: rtl/q_flop_driver.sv
`default_nettype none
// ============================================================================
//  Module      : q_flop_driver
//  Description : Initiator side of the q_flop sampling interface. Accepts a
//                WIDTH-bit word and shifts it LSB-first through an external
//                q_flop with a 4-phase per-bit handshake, then returns the
//                captured word with mismatch and timeout flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module q_flop_driver #(
    parameter int WIDTH   = 8,
    parameter int SETUP   = 1,
    parameter int TIMEOUT = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             qf_data,
    output logic             qf_clock,
    input  logic             qf_ack,
    input  logic             qf_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_mismatch,
    output logic             res_timeout
);

    localparam int c_IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int c_SW = $clog2(SETUP + 1);
    localparam int c_TW = $clog2(TIMEOUT + 1);

    localparam logic [c_IW-1:0] c_LAST_IDX   = c_IW'(WIDTH - 1);
    localparam logic [c_SW-1:0] c_SETUP_LAST = c_SW'(SETUP - 1);
    localparam logic [c_TW-1:0] c_TMO_LAST   = c_TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_RISE  = 3'd2,
        S_FALL  = 3'd3,
        S_DONE  = 3'd4,
        S_ABORT = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_state_n;

    logic             r_ack_meta;
    logic             r_ack_s;
    logic [WIDTH-1:0] r_word;
    logic [WIDTH-1:0] r_expect;
    logic [WIDTH-1:0] r_cap;
    logic [c_IW-1:0]  r_idx;
    logic [c_SW-1:0]  r_cnt;
    logic [c_TW-1:0]  r_tmo;

    logic             w_accept;
    logic             w_capture;
    logic             w_next_bit;
    logic [WIDTH-1:0] w_word_nx;

    // The word register shifts right so the next bit to drive is always bit 0.
    assign w_word_nx = r_word >> 1;

    // Two-flop synchroniser for the asynchronous acknowledge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ack_meta <= 1'b0;
            r_ack_s    <= 1'b0;
        end else begin
            r_ack_meta <= qf_ack;
            r_ack_s    <= r_ack_meta;
        end
    end

    // Next-state decode and per-cycle datapath strobes.
    always_comb begin
        w_state_n  = r_state;
        w_accept   = 1'b0;
        w_capture  = 1'b0;
        w_next_bit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_accept  = 1'b1;
                    w_state_n = S_SETUP;
                end
            end
            S_SETUP: begin
                // A lingering ack from the previous bit holds off the count.
                if (!r_ack_s && (r_cnt == c_SETUP_LAST)) begin
                    w_state_n = S_RISE;
                end
            end
            S_RISE: begin
                if (r_ack_s) begin
                    w_capture = 1'b1;
                    w_state_n = S_FALL;
                end else if (r_tmo == c_TMO_LAST) begin
                    w_state_n = S_ABORT;
                end
            end
            S_FALL: begin
                if (!r_ack_s) begin
                    if (r_idx == c_LAST_IDX) begin
                        w_state_n = S_DONE;
                    end else begin
                        w_next_bit = 1'b1;
                        w_state_n  = S_SETUP;
                    end
                end else if (r_tmo == c_TMO_LAST) begin
                    w_state_n = S_ABORT;
                end
            end
            S_DONE, S_ABORT: begin
                if (res_ready) begin
                    w_state_n = S_IDLE;
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    // State register, counters, word/capture registers and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_word       <= '0;
            r_expect     <= '0;
            r_cap        <= '0;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_tmo        <= '0;
            in_ready     <= 1'b1;
            qf_data      <= 1'b0;
            qf_clock     <= 1'b0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_mismatch <= 1'b0;
            res_timeout  <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            in_ready  <= (w_state_n == S_IDLE);
            qf_clock  <= (w_state_n == S_RISE);
            res_valid <= (w_state_n == S_DONE) || (w_state_n == S_ABORT);

            // Setup counter restarts on entry and stalls while ack is still high.
            if ((w_state_n == S_SETUP) && (r_state != S_SETUP)) begin
                r_cnt <= '0;
            end else if (r_state == S_SETUP) begin
                r_cnt <= r_ack_s ? '0 : r_cnt + c_SW'(1);
            end

            // Timeout counter restarts on every state change.
            if (w_state_n != r_state) begin
                r_tmo <= '0;
            end else if ((r_state == S_RISE) || (r_state == S_FALL)) begin
                r_tmo <= r_tmo + c_TW'(1);
            end

            if (w_accept) begin
                r_word   <= in_data;
                r_expect <= in_data;
                r_cap    <= '0;
                r_idx    <= '0;
                qf_data  <= in_data[0];
            end

            if (w_capture) begin
                r_cap[r_idx] <= qf_out;
            end

            if (w_next_bit) begin
                r_idx   <= r_idx + c_IW'(1);
                r_word  <= w_word_nx;
                qf_data <= w_word_nx[0];
            end

            if ((w_state_n == S_DONE) && (r_state != S_DONE)) begin
                res_data     <= r_cap;
                res_mismatch <= (r_cap != r_expect);
                res_timeout  <= 1'b0;
            end

            if ((w_state_n == S_ABORT) && (r_state != S_ABORT)) begin
                res_data     <= r_cap;
                res_mismatch <= 1'b1;
                res_timeout  <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_q_flop_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_q_flop_driver
//  Description : Self-checking bench for q_flop_driver with a behavioural
//                q_flop model and a result scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_q_flop_driver;

    localparam int WIDTH = 8;

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             qf_data;
    logic             qf_clock;
    logic             qf_ack;
    logic             qf_out;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_mismatch;
    logic             res_timeout;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             mm;
        logic             to;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // q_flop model: 0 ideal, 1 invert bit 3, 2 ack tied low, 3 ack stuck after bit 2 rises
    int   mode     = 0;
    int   rcnt     = 0;
    int   curbit   = 0;
    logic stuck    = 1'b0;
    logic clk_prev = 1'b0;
    logic ack_q    = 1'b0;

    q_flop_driver #(.WIDTH(WIDTH), .SETUP(1), .TIMEOUT(15)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .qf_data      (qf_data),
        .qf_clock     (qf_clock),
        .qf_ack       (qf_ack),
        .qf_out       (qf_out),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_mismatch (res_mismatch),
        .res_timeout  (res_timeout)
    );

    always #5 clock = ~clock;

    // Behavioural q_flop: ack follows qf_clock one cycle later, out follows data.
    always @(posedge clock) begin
        clk_prev <= qf_clock;
        if (in_ready === 1'b1) begin
            rcnt  <= 0;
            stuck <= 1'b0;
        end else if (qf_clock && !clk_prev) begin
            rcnt   <= rcnt + 1;
            curbit <= rcnt;
            if (mode == 3 && rcnt == 2) stuck <= 1'b1;
        end
        ack_q <= (mode == 2) ? 1'b0 : (stuck || qf_clock);
    end

    assign qf_ack = ack_q;
    assign qf_out = qf_data ^ ((mode == 1) && (curbit == 3));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: one comparison set per accepted result.
    always @(negedge clock) begin
        if (reset === 1'b0 && res_valid === 1'b1 && res_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 32'(sb.size()), 32'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("res_data", 32'(res_data), 32'(e.d));
                chk("res_mismatch", 32'(res_mismatch), 32'(e.mm));
                chk("res_timeout", 32'(res_timeout), 32'(e.to));
                chk("qf_clock_at_result", 32'(qf_clock), 32'd0);
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] w, input logic [WIDTH-1:0] ed,
                        input logic mm, input logic to);
        int n = 0;
        @(negedge clock);
        while (!in_ready && n < 1000) begin
            @(negedge clock);
            n++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        if (in_ready) begin
            in_valid = 1'b1;
            in_data  = w;
            @(posedge clock);
            sb.push_back('{d: ed, mm: mm, to: to});
            @(negedge clock);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 2000) begin
            @(negedge clock);
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        res_ready = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_qf_clock", 32'(qf_clock), 32'd0);
        chk("rst_qf_data", 32'(qf_data), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        reset = 1'b0;

        // Ideal loopback with latency: 8 bits x (1 setup + 4 rise + 4 fall)
        mode = 0;
        send(8'hA5, 8'hA5, 1'b0, 1'b0);
        n = 0;
        while (!res_valid && n < 300) begin
            @(negedge clock);
            n++;
        end
        chk("latency_A5", 32'(n), 32'd72);
        drain();

        // Bit 3 inverted by the model
        mode = 1;
        send(8'hFF, 8'hF7, 1'b1, 1'b0);
        drain();

        // Ack never arrives: abort from RISE on bit 0
        mode = 2;
        send(8'h01, 8'h00, 1'b1, 1'b1);
        drain();

        // Ack stuck high from bit 2: abort from FALL, bits 0..2 captured
        mode = 3;
        send(8'hFF, 8'h07, 1'b1, 1'b1);
        drain();

        // Reset during RISE of bit 4
        mode = 0;
        send(8'hC3, 8'hC3, 1'b0, 1'b0);
        n = 0;
        while (!(qf_clock && rcnt == 5) && n < 300) begin
            @(negedge clock);
            n++;
        end
        chk("reach_bit4_rise", 32'(qf_clock), 32'd1);
        reset = 1'b1;
        sb.delete();
        @(negedge clock);
        reset = 1'b0;
        chk("mid_rst_qf_clock", 32'(qf_clock), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
        send(8'h3C, 8'h3C, 1'b0, 1'b0);
        drain();

        // Result held while res_ready is low; in_valid ignored
        res_ready = 1'b0;
        send(8'h5A, 8'h5A, 1'b0, 1'b0);
        n = 0;
        while (!res_valid && n < 300) begin
            @(negedge clock);
            n++;
        end
        chk("hold_res_valid_rise", 32'(res_valid), 32'd1);
        in_valid = 1'b1;
        in_data  = 8'hEE;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("hold_res_valid", 32'(res_valid), 32'd1);
            chk("hold_res_data", 32'(res_data), 32'h5A);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_qf_clock", 32'(qf_clock), 32'd0);
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        drain();

        // Back-to-back words, results in order
        send(8'h12, 8'h12, 1'b0, 1'b0);
        send(8'h34, 8'h34, 1'b0, 1'b0);
        drain();

        repeat (5) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
